// File: rtl/aes_key_schedule.sv
// rtl/aes_key_schedule.sv - iterative AES-128 key expansion with indexed round-key readout
//
// Purpose: loads a 128-bit cipher key and expands it into round keys 1..10,
//   one round per step of SBOX_LAT+1 cycles. All 11 round keys are stored
//   and each one becomes readable as soon as it has been written.
// Ports:
//   clk        clock, all logic on posedge
//   rst        synchronous active-high reset
//   key_in     cipher key, [127:96]=w0 .. [31:0]=w3
//   key_load   start expansion (ignored while busy)
//   busy       expansion in progress
//   keys_ready all 11 round keys valid
//   rd_round   round-key index to read (0..15)
//   rd_key     registered round key for rd_round, 0 if not yet produced
// Optional feature (macro KEYSCHED_STREAM_EN):
//   rk_valid / rk_idx / rk_out stream out every round key as it is written.
// Sub-module aes_sbox: one S instance, LAT registered stages.

module aes_sbox #(
    parameter int LAT = 1
) (
    input  logic       clk_i,
    input  logic [7:0] in_i,
    output logic [7:0] out_o
);

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Multiplicative inverse as x^254 (maps 0 to 0, as the S-box requires).
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] x3, x7, x15, x31, x63, x127;
        x3   = gf_mul(gf_mul(x, x), x);
        x7   = gf_mul(gf_mul(x3, x3), x);
        x15  = gf_mul(gf_mul(x7, x7), x);
        x31  = gf_mul(gf_mul(x15, x15), x);
        x63  = gf_mul(gf_mul(x31, x31), x);
        x127 = gf_mul(gf_mul(x63, x63), x);
        return gf_mul(x127, x127);
    endfunction

    function automatic logic [7:0] sbox_f(input logic [7:0] x);
        logic [7:0] b;
        b = gf_inv(x);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
                 ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    logic [7:0] pipe_q [LAT];

    always_ff @(posedge clk_i) begin
        pipe_q[0] <= sbox_f(in_i);
        for (int i = 1; i < LAT; i++) begin
            pipe_q[i] <= pipe_q[i-1];
        end
    end

    assign out_o = pipe_q[LAT-1];

endmodule

module aes_key_schedule #(
    parameter int NR       = 10,
    parameter int SBOX_LAT = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [127:0] key_in,
    input  logic         key_load,
    output logic         busy,
    output logic         keys_ready,
    input  logic [3:0]   rd_round,
    output logic [127:0] rd_key
`ifdef KEYSCHED_STREAM_EN
    ,
    output logic         rk_valid,
    output logic [3:0]   rk_idx,
    output logic [127:0] rk_out
`endif
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SUB,
        S_MIX,
        S_DONE
    } state_e;

    state_e       state_q;
    logic         busy_q;
    logic         keys_ready_q;
    logic [127:0] rd_key_q;
    logic [3:0]   rounds_done_q;
    logic [7:0]   rcon_q;
    logic [3:0]   sub_cnt_q;
    // Copy of the most recently written round key; avoids a second
    // indexed read port on the storage array.
    logic [127:0] last_q;
    logic [127:0] rk_q [0:NR];

    logic         load_go;
    logic         mix_go;
    logic [31:0]  rot_w;
    logic [31:0]  sub_w;
    logic [127:0] next_key_d;

    assign load_go = key_load && ((state_q == S_IDLE) || (state_q == S_DONE));
    assign mix_go  = (state_q == S_MIX);

    // RotWord of w3 of the previous round key
    assign rot_w = {last_q[23:0], last_q[31:24]};

    for (genvar g = 0; g < 4; g++) begin : g_sbox
        aes_sbox #(
            .LAT (SBOX_LAT)
        ) u_sbox (
            .clk_i (clk),
            .in_i  (rot_w[8*g +: 8]),
            .out_o (sub_w[8*g +: 8])
        );
    end

    always_comb begin
        logic [31:0] t, w4, w5, w6, w7;
        t  = sub_w ^ {rcon_q, 24'h000000};
        w4 = last_q[127:96] ^ t;
        w5 = last_q[95:64]  ^ w4;
        w6 = last_q[63:32]  ^ w5;
        w7 = last_q[31:0]   ^ w6;
        next_key_d = {w4, w5, w6, w7};
    end

    // Key storage is never cleared; rounds_done_q hides stale entries.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (load_go) begin
                rk_q[0] <= key_in;
            end else if (mix_go) begin
                rk_q[rounds_done_q] <= next_key_d;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            busy_q        <= 1'b0;
            keys_ready_q  <= 1'b0;
            rd_key_q      <= '0;
            rounds_done_q <= 4'd0;
            rcon_q        <= 8'h01;
            sub_cnt_q     <= 4'd0;
            last_q        <= '0;
`ifdef KEYSCHED_STREAM_EN
            rk_valid      <= 1'b0;
            rk_idx        <= 4'd0;
            rk_out        <= '0;
`endif
        end else begin
            // rounds_done_q is the pre-update count, so a key written on this
            // edge becomes readable from the next sampling edge.
            rd_key_q <= (rd_round < rounds_done_q) ? rk_q[rd_round] : '0;
`ifdef KEYSCHED_STREAM_EN
            rk_valid <= 1'b0;
`endif
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (key_load) begin
                        last_q        <= key_in;
                        rounds_done_q <= 4'd1;
                        rcon_q        <= 8'h01;
                        busy_q        <= 1'b1;
                        keys_ready_q  <= 1'b0;
                        sub_cnt_q     <= 4'd0;
                        state_q       <= S_SUB;
`ifdef KEYSCHED_STREAM_EN
                        rk_valid      <= 1'b1;
                        rk_idx        <= 4'd0;
                        rk_out        <= key_in;
`endif
                    end
                end
                S_SUB: begin
                    // Input to the S instances is held for SBOX_LAT cycles so
                    // the registered result is valid during MIX.
                    if (sub_cnt_q == 4'(SBOX_LAT - 1)) begin
                        sub_cnt_q <= 4'd0;
                        state_q   <= S_MIX;
                    end else begin
                        sub_cnt_q <= sub_cnt_q + 4'd1;
                    end
                end
                S_MIX: begin
                    last_q        <= next_key_d;
                    rounds_done_q <= rounds_done_q + 4'd1;
                    rcon_q        <= {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
`ifdef KEYSCHED_STREAM_EN
                    rk_valid      <= 1'b1;
                    rk_idx        <= rounds_done_q;
                    rk_out        <= next_key_d;
`endif
                    if (rounds_done_q == 4'(NR)) begin
                        busy_q       <= 1'b0;
                        keys_ready_q <= 1'b1;
                        state_q      <= S_DONE;
                    end else begin
                        state_q <= S_SUB;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy       = busy_q;
    assign keys_ready = keys_ready_q;
    assign rd_key     = rd_key_q;

endmodule

// File: tb/tb_aes_key_schedule.sv
// tb/tb_aes_key_schedule.sv - directed-vector bench for aes_key_schedule

module tb_aes_key_schedule;

    localparam logic [127:0] KEY_A1  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] A1_RK1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] A1_RK2  = 128'hf2c295f27a96b9435935807a7359f67f;
    localparam logic [127:0] A1_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] Z_RK1   = 128'h62636363626363636263636362636363;
    localparam logic [127:0] Z_RK10  = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

    logic         clk;
    logic         rst;
    logic [127:0] key_in;
    logic         key_load;
    logic         busy;
    logic         keys_ready;
    logic [3:0]   rd_round;
    logic [127:0] rd_key;
`ifdef KEYSCHED_STREAM_EN
    logic         rk_valid;
    logic [3:0]   rk_idx;
    logic [127:0] rk_out;
    int           st_cnt;
    int           st_idx_err;
    logic [127:0] st_rk1;
`endif

    int n_cmp;
    int n_err;

    aes_key_schedule u_dut (
        .clk        (clk),
        .rst        (rst),
        .key_in     (key_in),
        .key_load   (key_load),
        .busy       (busy),
        .keys_ready (keys_ready),
        .rd_round   (rd_round),
        .rd_key     (rd_key)
`ifdef KEYSCHED_STREAM_EN
        ,
        .rk_valid   (rk_valid),
        .rk_idx     (rk_idx),
        .rk_out     (rk_out)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef KEYSCHED_STREAM_EN
    always @(negedge clk) begin
        if (rk_valid) begin
            if (rk_idx != st_cnt[3:0]) st_idx_err++;
            if (rk_idx == 4'd1) st_rk1 = rk_out;
            st_cnt++;
        end
    end
`endif

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One rising edge, then settle 1 time unit past it.
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic rd(input string tag, input logic [3:0] idx, input logic [127:0] exp);
        rd_round = idx;
        tick(1);
        chk(tag, rd_key, exp);
    endtask

    initial begin
        int edges;
        n_cmp    = 0;
        n_err    = 0;
        rst      = 1'b1;
        key_in   = '0;
        key_load = 1'b0;
        rd_round = 4'd0;
`ifdef KEYSCHED_STREAM_EN
        st_cnt     = 0;
        st_idx_err = 0;
        st_rk1     = '0;
`endif
        tick(2);
        chk("rst_busy", 128'(busy), 128'd0);
        chk("rst_ready", 128'(keys_ready), 128'd0);
        chk("rst_rdkey", rd_key, 128'd0);
        rst = 1'b0;
        tick(1);

        // A.1 expansion with early reads and an ignored mid-run load
        key_in   = KEY_A1;
        key_load = 1'b1;
        tick(1);                               // edge 0
        key_load = 1'b0;
        chk("a1_busy_e0", 128'(busy), 128'd1);
        chk("a1_ready_e0", 128'(keys_ready), 128'd0);
        tick(2);                               // edge 2: rk1 written
        rd("early_rk1", 4'd1, A1_RK1);         // edge 3
        rd("early_rk2_hidden", 4'd2, 128'd0);  // edge 4
        key_in   = '0;
        key_load = 1'b1;
        tick(1);                               // edge 5: ignored
        key_load = 1'b0;
        tick(14);                              // edge 19
        chk("a1_ready_e19", 128'(keys_ready), 128'd0);
        chk("a1_busy_e19", 128'(busy), 128'd1);
        tick(1);                               // edge 20
        chk("a1_ready_e20", 128'(keys_ready), 128'd1);
        chk("a1_busy_e20", 128'(busy), 128'd0);
        rd("a1_rk0", 4'd0, KEY_A1);
        rd("a1_rk1", 4'd1, A1_RK1);
        rd("a1_rk2", 4'd2, A1_RK2);
        rd("a1_rk10", 4'd10, A1_RK10);
        rd("a1_rk11", 4'd11, 128'd0);

        // Restart from DONE with an all-zero key
        key_in   = '0;
        key_load = 1'b1;
        tick(1);
        key_load = 1'b0;
        chk("z_ready_e0", 128'(keys_ready), 128'd0);
        chk("z_busy_e0", 128'(busy), 128'd1);
        tick(20);
        chk("z_ready_e20", 128'(keys_ready), 128'd1);
        rd("z_rk1", 4'd1, Z_RK1);
        rd("z_rk10", 4'd10, Z_RK10);
        rd("z_rk13", 4'd13, 128'd0);

        // Reset mid-expansion, then reload A.1
        key_in   = KEY_A1;
        key_load = 1'b1;
        tick(1);                               // edge 0
        key_load = 1'b0;
        tick(6);                               // edge 6
        rst = 1'b1;
        tick(1);                               // edge 7
        rst = 1'b0;
        chk("mid_rst_busy", 128'(busy), 128'd0);
        chk("mid_rst_ready", 128'(keys_ready), 128'd0);
        rd("mid_rst_rk0", 4'd0, 128'd0);
        rd("mid_rst_rk1", 4'd1, 128'd0);
`ifdef KEYSCHED_STREAM_EN
        st_cnt     = 0;
        st_idx_err = 0;
        st_rk1     = '0;
`endif
        key_load = 1'b1;
        tick(1);                               // reload edge 0
        key_load = 1'b0;
        edges = 0;
        while (!keys_ready && edges < 40) begin
            tick(1);
            edges++;
        end
        chk("reload_edges", 128'(edges), 128'd20);
        rd("reload_rk10", 4'd10, A1_RK10);
        rd("reload_rk1", 4'd1, A1_RK1);
`ifdef KEYSCHED_STREAM_EN
        chk("st_pulses", 128'(st_cnt), 128'd11);
        chk("st_idx_order", 128'(st_idx_err), 128'd0);
        chk("st_rk1", st_rk1, A1_RK1);
`endif

        // rst and key_load together: rst wins
        rst      = 1'b1;
        key_load = 1'b1;
        tick(1);
        rst      = 1'b0;
        key_load = 1'b0;
        chk("rst_load_busy", 128'(busy), 128'd0);
        chk("rst_load_ready", 128'(keys_ready), 128'd0);
        tick(2);
        chk("rst_load_idle", 128'(busy), 128'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
